code_84n2n1_counter: RTL and testbench
======================================

// Module: code_84n2n1_counter
// PURPOSE
//   Synchronous multi-digit decade counter whose digits are held directly in 8,4,-2,-1 code.
//   Upstream source stage for the 8,4,-2,-1 -> BCD / Gray code converters; each 4-bit digit
//   is a legal converter input word.
//   Supports up/down counting, parallel load with legality check, and a wrap (carry/borrow) pulse.
// PARAMETERS
//   DIGITS  2  number of decade digits; digit 0 is least significant, in bits [3:0]
// PORTS
//   clk       in   1           single clock, all state updates on rising edge
//   rst       in   1           synchronous, active-high reset
//   en        in   1           count enable; one step per cycle while high
//   up        in   1           1 = count up, 0 = count down (sampled only when en=1)
//   load      in   1           parallel load request
//   load_val  in   4*DIGITS    value to load, 8,4,-2,-1 coded digits
//   X         out  4*DIGITS    current count, 8,4,-2,-1 coded digits
//   wrap      out  1           one-cycle pulse: count wrapped (99..9->0..0 up, 0..0->99..9 down)
//   err       out  1           last load attempt contained an illegal digit (sticky)
// BEHAVIOUR
//   - Legal digit codes, value 0..9: 0000,0111,0110,0101,0100,1011,1010,1001,1000,1111.
//     The other six codes are illegal.
//   - Reset (rst=1 at edge): X=all 0000, wrap=0, err=0. Reset overrides load and en.
//   - Priority at each edge: rst > load > en. en=0 with no load: X holds, wrap=0.
//   - Load, legal: every digit of load_val is legal. X<=load_val, err<=0, wrap<=0.
//     Load takes effect in 1 cycle. No count occurs in a load cycle, even if en=1.
//   - Load, illegal: any digit of load_val is illegal. X unchanged, err<=1, wrap<=0.
//   - err persists until reset or the next legal load.
//   - Count up: digit0 always steps. Digit i>0 steps only when all lower digits are 9 (1111).
//     Step 9 (1111) -> 0 (0000).
//   - Count down: digit0 always steps. Digit i>0 steps only when all lower digits are 0 (0000).
//     Step 0 (0000) -> 9 (1111).
//   - Carry/borrow chain is purely combinational within one cycle. Counter latency is 1 cycle.
//   - wrap is registered and goes high in the same cycle the wrapped X appears:
//     - up:   set when X was all 1111 before the edge;
//     - down: set when X was all 0000 before the edge.
//     wrap is low in every other cycle.
//   - Direction change mid-count needs no idle cycle. The next step follows the new up value.
//   - X never holds an illegal code, because load is guarded and the step function is closed
//     over legal codes.
//   - Simulation-only assertion: if an illegal digit is forced into X, the digit steps to 0000.
// STRUCTURE
//   - Shared package code84_pkg:
//     - localparams CODE_D0..CODE_D9;
//     - function is_legal(4b) -> 1b;
//     - functions step_up(4b) and step_dn(4b) -> 4b.
//     The converter stages and their benches reuse these constants.
//   - Sub-module code_84n2n1_digit: one digit register with inputs clk, rst, ld, ld_val, step,
//     up. Outputs: q, and at_term (q==9 when up, q==0 when down).
//   - Top: generate-for over DIGITS instances, AND-chains of at_term forming each step enable,
//     plus wrap/err registers.
// TESTING (DIGITS=2)
//   1. Reset: rst=1 for 2 cycles with en=1, load=1 -> X=8'h00, wrap=0, err=0.
//   2. Up count: en=1, up=1 for 10 cycles from 00.
//      - digit0 goes 0111,0110,0101,0100,1011,1010,1001,1000,1111, then 0000.
//      - After the 10th edge, X=8'b0111_0000 (decimal 10); wrap stays 0.
//   3. Wrap up/down:
//      - load 8'b1111_1111 (99), en=1, up=1 -> X=8'h00, wrap=1 for exactly one cycle.
//      - Then up=0 -> X=8'hFF, wrap=1 one cycle.
//   4. Illegal load:
//      - From X=8'b0111_0110 (12), load_val=8'b0001_0000 -> X unchanged, err=1.
//      - err remains 1 through 5 count cycles.
//      - Legal load 8'b0000_1000 -> X=8'b0000_1000, err=0.
//   5. Simultaneous load+en: load=1, load_val=8'b1011_1011 (55), en=1, up=1
//      -> X=8'b1011_1011 (no step), wrap=0. Next cycle with en only -> 8'b1011_1010 (56).
//   6. Reset mid-operation: count to 8'b0110_1000 (28), assert rst for one edge with en=1
//      -> X=8'h00, wrap=0. Counting resumes next cycle to 8'b0000_0111 (01).

Source files
------------

// File: rtl/code_84n2n1_counter_pkg.sv
// Shared 8,4,-2,-1 digit-code constants and step helpers.
// Reused by the converter stages and their benches.
package code84_pkg;

  localparam logic [3:0] CODE_D0 = 4'b0000;
  localparam logic [3:0] CODE_D1 = 4'b0111;
  localparam logic [3:0] CODE_D2 = 4'b0110;
  localparam logic [3:0] CODE_D3 = 4'b0101;
  localparam logic [3:0] CODE_D4 = 4'b0100;
  localparam logic [3:0] CODE_D5 = 4'b1011;
  localparam logic [3:0] CODE_D6 = 4'b1010;
  localparam logic [3:0] CODE_D7 = 4'b1001;
  localparam logic [3:0] CODE_D8 = 4'b1000;
  localparam logic [3:0] CODE_D9 = 4'b1111;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      CODE_D0, CODE_D1, CODE_D2, CODE_D3, CODE_D4,
      CODE_D5, CODE_D6, CODE_D7, CODE_D8, CODE_D9: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Illegal codes fall back to 0 so a corrupted digit recovers on its next step.
  function automatic logic [3:0] step_up(input logic [3:0] c);
    case (c)
      CODE_D0: return CODE_D1;
      CODE_D1: return CODE_D2;
      CODE_D2: return CODE_D3;
      CODE_D3: return CODE_D4;
      CODE_D4: return CODE_D5;
      CODE_D5: return CODE_D6;
      CODE_D6: return CODE_D7;
      CODE_D7: return CODE_D8;
      CODE_D8: return CODE_D9;
      default: return CODE_D0;
    endcase
  endfunction

  function automatic logic [3:0] step_dn(input logic [3:0] c);
    case (c)
      CODE_D0: return CODE_D9;
      CODE_D9: return CODE_D8;
      CODE_D8: return CODE_D7;
      CODE_D7: return CODE_D6;
      CODE_D6: return CODE_D5;
      CODE_D5: return CODE_D4;
      CODE_D4: return CODE_D3;
      CODE_D3: return CODE_D2;
      CODE_D2: return CODE_D1;
      default: return CODE_D0;
    endcase
  endfunction

endpackage

// File: rtl/code_84n2n1_counter_if.sv
// Control/data bundle of the 8,4,-2,-1 decade counter.
interface code_84n2n1_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   X;
  logic                  wrap;
  logic                  err;

  modport master (output en, up, load, load_val, input X, wrap, err);
  modport slave  (input en, up, load, load_val, output X, wrap, err);
endinterface

// File: rtl/code_84n2n1_digit.sv
// One 8,4,-2,-1 coded decade digit with load, step and terminal-count flag.
module code_84n2n1_digit
  import code84_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q,
  output logic       at_term
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld)
      q_d = ld_val;
    else if (step)
      q_d = up ? step_up(q_q) : step_dn(q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= CODE_D0;
    else     q_q <= q_d;
  end

  assign q       = q_q;
  assign at_term = up ? (q_q == CODE_D9) : (q_q == CODE_D0);

  ill_step_a: assert property (@(posedge clk) disable iff (rst)
    (step && !ld && !is_legal(q_q)) |=> (q_q == CODE_D0));

endmodule

// File: rtl/code_84n2n1_counter.sv
// Multi-digit up/down decade counter holding digits in 8,4,-2,-1 code,
// with guarded parallel load, sticky load-error flag and wrap pulse.
module code_84n2n1_counter
  import code84_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  code_84n2n1_counter_if.slave   bus
);

  logic [DIGITS:0]       chain;
  logic [DIGITS-1:0]     at_term;
  logic [DIGITS-1:0]     legal;
  logic [4*DIGITS-1:0]   x_w;
  logic                  load_ok;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;

  // Load beats counting, so a load cycle never lets the step chain start.
  assign chain[0] = bus.en & ~bus.load;
  assign load_ok  = bus.load & (&legal);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign legal[g]     = is_legal(bus.load_val[4*g +: 4]);
    assign chain[g+1]   = chain[g] & at_term[g];

    code_84n2n1_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .ld      (load_ok),
      .ld_val  (bus.load_val[4*g +: 4]),
      .step    (chain[g]),
      .up      (bus.up),
      .q       (x_w[4*g +: 4]),
      .at_term (at_term[g])
    );
  end

  // A full chain means every digit sat at its terminal value before this edge.
  always_comb begin
    wrap_d = chain[DIGITS];
    err_d  = bus.load ? ~(&legal) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.X    = x_w;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_code_84n2n1_counter.sv
// Bench for code_84n2n1_counter (DIGITS=2): directed scenarios plus random traffic
// against a decimal-value reference model.
module tb_code_84n2n1_counter;

  localparam int D    = 2;
  localparam int MAXV = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_84n2n1_counter_if #(.DIGITS(D)) bus ();

  code_84n2n1_counter #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain decimal value plus flags.
  int m_cnt  = 0;
  bit m_wrap = 1'b0;
  bit m_err  = 1'b0;

  logic [3:0] codes [10] = '{4'b0000, 4'b0111, 4'b0110, 4'b0101, 4'b0100,
                             4'b1011, 4'b1010, 4'b1001, 4'b1000, 4'b1111};

  function automatic logic [7:0] enc(input int n);
    logic [7:0] v;
    v[3:0] = codes[n % 10];
    v[7:4] = codes[(n / 10) % 10];
    return v;
  endfunction

  function automatic int dec(input logic [7:0] v);
    int lo, hi;
    lo = -1;
    hi = -1;
    for (int k = 0; k < 10; k++) begin
      if (codes[k] == v[3:0]) lo = k;
      if (codes[k] == v[7:4]) hi = k;
    end
    if (lo < 0 || hi < 0) return -1;
    return hi * 10 + lo;
  endfunction

  task automatic tick(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
    int v;
    rst          = r;
    bus.en       = e;
    bus.up       = u;
    bus.load     = l;
    bus.load_val = lv;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_err = 0;
    end else if (l) begin
      m_wrap = 0;
      v = dec(lv);
      if (v < 0) m_err = 1;
      else begin m_cnt = v; m_err = 0; end
    end else if (e) begin
      if (u) begin m_wrap = (m_cnt == MAXV); m_cnt = (m_cnt + 1) % (MAXV + 1); end
      else   begin m_wrap = (m_cnt == 0);    m_cnt = (m_cnt + MAXV) % (MAXV + 1); end
    end else begin
      m_wrap = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 1, 1, 8'h77);
      checks++;
      if (bus.X !== 8'h00 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL reset: X=%b wrap=%b err=%b required X=00000000 wrap=0 err=0",
                 bus.X, bus.wrap, bus.err);
      end
    end
  endtask

  task automatic test_up_count();
    logic [3:0] seq [10] = '{4'b0111, 4'b0110, 4'b0101, 4'b0100, 4'b1011,
                             4'b1010, 4'b1001, 4'b1000, 4'b1111, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 1, 0, 8'h00);
      checks++;
      if (bus.X[3:0] !== seq[i] || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL up_count step %0d: digit0=%b wrap=%b required digit0=%b wrap=0",
                 i, bus.X[3:0], bus.wrap, seq[i]);
      end
    end
    checks++;
    if (bus.X !== 8'b0111_0000) begin
      errors++;
      $display("FAIL up_count ten: X=%b required 01110000", bus.X);
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1, 1, 8'b1111_1111);
    checks++;
    if (bus.X !== 8'hFF || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap load99: X=%b wrap=%b required X=11111111 wrap=0", bus.X, bus.wrap);
    end
    tick(0, 1, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'h00 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap up: X=%b wrap=%b required X=00000000 wrap=1", bus.X, bus.wrap);
    end
    tick(0, 0, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap up pulse: X=%b wrap=%b required X=00000000 wrap=0", bus.X, bus.wrap);
    end
    tick(0, 1, 0, 0, 8'h00);
    checks++;
    if (bus.X !== 8'hFF || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap down: X=%b wrap=%b required X=11111111 wrap=1", bus.X, bus.wrap);
    end
    tick(0, 1, 0, 0, 8'h00);
    checks++;
    if (bus.X !== enc(98) || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap down pulse: X=%b wrap=%b required X=%b wrap=0", bus.X, bus.wrap, enc(98));
    end
  endtask

  task automatic test_illegal_load();
    tick(0, 0, 1, 1, 8'b0111_0110);
    tick(0, 1, 1, 1, 8'b0001_0000);
    checks++;
    if (bus.X !== 8'b0111_0110 || bus.err !== 1'b1 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL illegal_load: X=%b err=%b wrap=%b required X=01110110 err=1 wrap=0",
               bus.X, bus.err, bus.wrap);
    end
    for (int i = 1; i <= 5; i++) begin
      tick(0, 1, 1, 0, 8'h00);
      checks++;
      if (bus.err !== 1'b1 || bus.X !== enc(12 + i)) begin
        errors++;
        $display("FAIL illegal_sticky %0d: X=%b err=%b required X=%b err=1",
                 i, bus.X, bus.err, enc(12 + i));
      end
    end
    tick(0, 0, 1, 1, 8'b0000_1000);
    checks++;
    if (bus.X !== 8'b0000_1000 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL legal_reload: X=%b err=%b required X=00001000 err=0", bus.X, bus.err);
    end
  endtask

  task automatic test_load_en();
    tick(0, 1, 1, 1, 8'b1011_1011);
    checks++;
    if (bus.X !== 8'b1011_1011 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_en: X=%b wrap=%b required X=10111011 wrap=0", bus.X, bus.wrap);
    end
    tick(0, 1, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'b1011_1010) begin
      errors++;
      $display("FAIL load_en next: X=%b required 10111010", bus.X);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1, 1, enc(20));
    for (int i = 0; i < 8; i++) tick(0, 1, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'b0110_1000) begin
      errors++;
      $display("FAIL reset_mid count28: X=%b required 01101000", bus.X);
    end
    tick(1, 1, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: X=%b wrap=%b required X=00000000 wrap=0", bus.X, bus.wrap);
    end
    tick(0, 1, 1, 0, 8'h00);
    checks++;
    if (bus.X !== 8'b0000_0111) begin
      errors++;
      $display("FAIL reset_mid resume: X=%b required 00000111", bus.X);
    end
  endtask

  task automatic test_random();
    bit r, e, u, l;
    logic [7:0] lv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      lv = ($urandom_range(0, 1) == 1) ? enc($urandom_range(0, MAXV))
                                       : 8'($urandom_range(0, 255));
      tick(r, e, u, l, lv);
      checks++;
      if (bus.X !== enc(m_cnt) || bus.wrap !== m_wrap || bus.err !== m_err) begin
        errors++;
        $display("FAIL random %0d: X=%b wrap=%b err=%b required X=%b wrap=%b err=%b",
                 i, bus.X, bus.wrap, bus.err, enc(m_cnt), m_wrap, m_err);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    test_reset();
    test_up_count();
    test_wrap();
    test_illegal_load();
    test_load_en();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
